update_dispatcher: RTL and testbench
====================================

UPDATE_DISPATCHER -- requirements
Module: update_dispatcher

Interface
REQ-001 SHALL have parameter PRED_W, default 6, vertex index width in bits.
REQ-002 SHALL have parameter WEIGHT_W, default 32, edge weight width in bits.
REQ-003 SHALL have parameter DEPTH, default 8, update queue entries (power of 2, >=2).
REQ-004 SHALL have parameter TIMEOUT, default 1048576, max cycles to wait for container completion.
REQ-005 SHALL have clk  in  1  sole clock; all state on rising edge.
REQ-006 SHALL have reset_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have wr_valid  in  1  host offers an update.
REQ-008 SHALL have wr_ready  out  1  queue can accept an update.
REQ-009 SHALL have wr_src, wr_dst  in  PRED_W each  edge endpoints.
REQ-010 SHALL have wr_weight  in  WEIGHT_W  new edge weight.
REQ-011 SHALL have u_src, u_dst  out  PRED_W each; u_e  out  WEIGHT_W  update presented to graph container.
REQ-012 SHALL have container_reset  out  1  one-cycle start pulse to container.
REQ-013 SHALL have container_done  in  1  container finished (sticky until next start).
REQ-014 SHALL have busy  out  1  a dispatch is in flight.
REQ-015 SHALL have pending  out  clog2(DEPTH)+1  queued entry count.
REQ-016 SHALL have run_count  out  16  completed dispatches, wraps 0xFFFF->0.
REQ-017 SHALL have error  out  1  sticky timeout flag.

Function
REQ-018 SHALL accept an update on any rising edge where wr_valid && wr_ready.
REQ-019 SHALL drive wr_ready = (pending != DEPTH), combinational from count, no bypass when full even if a pop occurs that cycle.
REQ-020 SHALL coalesce: accepted update whose (src,dst) equals a queued entry overwrites that entry's weight in place; pending unchanged; order unchanged.
REQ-021 SHALL match exact (src,dst) order only; (dst,src) is a distinct entry.
REQ-022 SHALL not coalesce with the entry popped in the same cycle; such a push is appended as new.
REQ-023 SHALL implement states IDLE, LOAD, KICK, WAIT_LOW, WAIT_HIGH.
REQ-024 IDLE: if pending>0 -> LOAD; else stay.
REQ-025 LOAD: pop queue head into u_src/u_dst/u_e; -> KICK.
REQ-026 KICK: container_reset=1 for exactly this cycle; -> WAIT_LOW.
REQ-027 WAIT_LOW: ignore stale container_done; when container_done==0 -> WAIT_HIGH.
REQ-028 WAIT_HIGH: when container_done==1 -> run_count+1, -> IDLE.
REQ-029 SHALL hold u_src/u_dst/u_e constant from LOAD until the next LOAD.
REQ-030 busy SHALL be 1 in LOAD, KICK, WAIT_LOW, WAIT_HIGH; 0 in IDLE.
REQ-031 SHALL count cycles spent in WAIT_LOW+WAIT_HIGH; on reaching TIMEOUT -> error=1, -> IDLE, run_count unchanged, entry discarded.
REQ-032 error SHALL stay 1 until reset; dispatching continues after timeout.
REQ-033 Simultaneous push and pop SHALL leave pending unchanged (non-coalesced push) or pending-1 (coalesced push).
REQ-034 Queue pointers SHALL wrap modulo DEPTH.

Reset
REQ-035 On reset_n=0, SHALL immediately clear: state=IDLE, queue empty, pending=0, u_src=u_dst=u_e=0, container_reset=0, busy=0, run_count=0, error=0, timeout counter=0.
REQ-036 Reset mid-dispatch SHALL abandon the in-flight update without counting it.
REQ-037 First action after reset release SHALL be no earlier than the next rising edge with reset_n=1.

Verification
REQ-038 Single push (3,5,0x10), container_done low 2 cycles after pulse then high 10 cycles later -> u_src=3,u_dst=5,u_e=0x10, one container_reset pulse, run_count=1, busy returns 0.
REQ-039 Push (1,2,7),(1,2,9) while busy -> pending=1, dispatched u_e=9, single pulse.
REQ-040 Push DEPTH distinct updates while busy -> wr_ready=0 at pending=8; extra push not accepted; all 8 dispatched FIFO order.
REQ-041 container_done held 1 throughout -> FSM waits in WAIT_LOW; after TIMEOUT cycles error=1, run_count unchanged, next queued entry dispatched.
REQ-042 reset_n low during WAIT_HIGH with pending=3 -> all outputs at reset values same cycle, no further pulses.

Source files
------------

// File: rtl/update_dispatcher_if.sv
`default_nettype none
// ============================================================================
//  Module      : update_dispatcher_if
//  Description : Host write channel plus graph-container handshake bundle
//                shared by the dispatcher and its environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface update_dispatcher_if #(
  parameter int PRED_W   = 6,
  parameter int WEIGHT_W = 32
);
  logic                wr_valid;
  logic                wr_ready;
  logic [PRED_W-1:0]   wr_src;
  logic [PRED_W-1:0]   wr_dst;
  logic [WEIGHT_W-1:0] wr_weight;
  logic [PRED_W-1:0]   u_src;
  logic [PRED_W-1:0]   u_dst;
  logic [WEIGHT_W-1:0] u_e;
  logic                container_reset;
  logic                container_done;

  // Environment side: host writer and graph container
  modport master (
    output wr_valid, wr_src, wr_dst, wr_weight, container_done,
    input  wr_ready, u_src, u_dst, u_e, container_reset
  );

  // Dispatcher side
  modport slave (
    input  wr_valid, wr_src, wr_dst, wr_weight, container_done,
    output wr_ready, u_src, u_dst, u_e, container_reset
  );
endinterface
`default_nettype wire

// File: rtl/update_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module      : update_dispatcher
//  Description : Coalescing update queue feeding a graph container one edge
//                update at a time, with a start pulse, completion handshake,
//                completion counter and sticky timeout flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module update_dispatcher #(
  parameter int PRED_W   = 6,
  parameter int WEIGHT_W = 32,
  parameter int DEPTH    = 8,
  parameter int TIMEOUT  = 1048576
) (
  input  logic                     clk,
  input  logic                     reset_n,
  update_dispatcher_if.slave       bus,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   pending,
  output logic [15:0]              run_count,
  output logic                     error
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] FULL    = CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_KICK      = 3'd2,
    S_WAIT_LOW  = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [PRED_W-1:0]   q_src [DEPTH];
  logic [PRED_W-1:0]   q_dst [DEPTH];
  logic [WEIGHT_W-1:0] q_w   [DEPTH];
  logic [PTR_W-1:0]    head, tail;
  logic [CNT_W-1:0]    count;
  logic [TO_W-1:0]     tcnt;

  logic              push_acc, push_new, coalesce, pop, hit;
  logic [PTR_W-1:0]  hit_idx;
  logic              done_hit, timeout_hit;

  // No bypass: a full queue refuses even when the head is leaving this cycle
  assign bus.wr_ready = (count != FULL);
  assign push_acc     = bus.wr_valid && bus.wr_ready;
  assign pop          = (state == S_LOAD);
  assign push_new     = push_acc && !hit;
  assign coalesce     = push_acc && hit;
  assign pending      = count;
  assign busy         = (state != S_IDLE);
  assign bus.container_reset = (state == S_KICK);

  // Find a live entry with the same ordered (src,dst); the head being popped is excluded
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(PTR_W'(PTR_W'(i) - head)) < count) &&
          !(pop && (PTR_W'(i) == head)) &&
          (q_src[i] == bus.wr_src) && (q_dst[i] == bus.wr_dst)) begin
        hit     = 1'b1;
        hit_idx = PTR_W'(i);
      end
    end
  end

  // Queue storage: append at tail, or overwrite the weight of a matching entry
  always_ff @(posedge clk) begin
    if (push_new) begin
      q_src[tail] <= bus.wr_src;
      q_dst[tail] <= bus.wr_dst;
      q_w[tail]   <= bus.wr_weight;
    end
    if (coalesce) begin
      q_w[hit_idx] <= bus.wr_weight;
    end
  end

  // Queue pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_new) tail <= tail + 1'b1;
      if (pop)      head <= head + 1'b1;
      case ({push_new, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Dispatch sequencing; completion wins over a timeout landing on the same cycle
  always_comb begin
    state_nxt   = state;
    done_hit    = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE:      if (count != '0) state_nxt = S_LOAD;
      S_LOAD:      state_nxt = S_KICK;
      S_KICK:      state_nxt = S_WAIT_LOW;
      S_WAIT_LOW: begin
        if (tcnt == TO_LAST) begin
          timeout_hit = 1'b1;
          state_nxt   = S_IDLE;
        end else if (!bus.container_done) begin
          state_nxt = S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: begin
        if (bus.container_done) begin
          done_hit  = 1'b1;
          state_nxt = S_IDLE;
        end else if (tcnt == TO_LAST) begin
          timeout_hit = 1'b1;
          state_nxt   = S_IDLE;
        end
      end
      default:     state_nxt = S_IDLE;
    endcase
  end

  // State register, wait timer, presented update and status counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      tcnt      <= '0;
      bus.u_src <= '0;
      bus.u_dst <= '0;
      bus.u_e   <= '0;
      run_count <= '0;
      error     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_KICK) begin
        tcnt <= '0;
      end else if ((state == S_WAIT_LOW) || (state == S_WAIT_HIGH)) begin
        tcnt <= tcnt + 1'b1;
      end
      if (pop) begin
        bus.u_src <= q_src[head];
        bus.u_dst <= q_dst[head];
        bus.u_e   <= q_w[head];
      end
      if (done_hit)    run_count <= run_count + 16'd1;
      if (timeout_hit) error     <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_update_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module      : tb_update_dispatcher
//  Description : Scoreboard bench for update_dispatcher with a queue-level
//                reference model and a behavioural graph container.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_update_dispatcher;

  localparam int PW    = 6;
  localparam int WW    = 32;
  localparam int DEPTH = 8;
  localparam int TO    = 64;

  typedef struct packed {
    logic [PW-1:0] s;
    logic [PW-1:0] d;
    logic [WW-1:0] w;
  } entry_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        busy, error;
  logic [3:0]  pending;
  logic [15:0] run_count;

  update_dispatcher_if #(.PRED_W(PW), .WEIGHT_W(WW)) bus ();

  update_dispatcher #(
    .PRED_W(PW), .WEIGHT_W(WW), .DEPTH(DEPTH), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .busy(busy), .pending(pending), .run_count(run_count), .error(error)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     failures = 0;
  entry_t mq[$];
  entry_t last_pop;
  entry_t push_e;
  bit     have_push, prev_busy, prev_pulse;
  int     cd1 = 2, cd2 = 10;
  bit     rand_delays = 1'b0, hang_next = 1'b0;
  int     exp_runs = 0, epoch = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: pop at the edge preceding each start pulse, then apply the push
  initial begin : monitor
    entry_t e;
    bit     found;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        mq.delete();
        have_push  = 1'b0;
        prev_busy  = 1'b0;
        prev_pulse = 1'b0;
      end else begin
        if (bus.container_reset) begin
          chk("pulse_width", 64'(prev_pulse), 64'(0));
          if (mq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL pulse_on_empty actual=pulse required=no_pulse");
          end else begin
            e = mq.pop_front();
            last_pop = e;
            chk("u_src", 64'(bus.u_src), 64'(e.s));
            chk("u_dst", 64'(bus.u_dst), 64'(e.d));
            chk("u_e",   64'(bus.u_e),   64'(e.w));
          end
        end
        if (have_push) begin
          found = 1'b0;
          foreach (mq[i]) begin
            if (!found && mq[i].s == push_e.s && mq[i].d == push_e.d) begin
              mq[i].w = push_e.w;
              found = 1'b1;
            end
          end
          if (!found) mq.push_back(push_e);
        end
        chk("pending",  64'(pending), 64'(mq.size()));
        chk("wr_ready", 64'(bus.wr_ready), 64'(mq.size() != DEPTH));
        if (prev_busy && !busy) begin
          chk("run_count_at_end", 64'(run_count), 64'(exp_runs));
          chk("u_hold", 64'({bus.u_src, bus.u_dst, bus.u_e}),
              64'({last_pop.s, last_pop.d, last_pop.w}));
        end
        have_push  = bus.wr_valid && (mq.size() != DEPTH);
        push_e.s   = bus.wr_src;
        push_e.d   = bus.wr_dst;
        push_e.w   = bus.wr_weight;
        prev_busy  = busy;
        prev_pulse = bus.container_reset;
      end
    end
  end

  // Graph container: on each start pulse drop done, later raise it again
  initial begin : container
    bus.container_done = 1'b1;
    forever begin
      @(negedge clk);
      if (reset_n && bus.container_reset) begin
        if (hang_next) begin
          hang_next = 1'b0;
        end else begin
          int my_epoch;
          int a, b;
          my_epoch = epoch;
          a = rand_delays ? int'($urandom_range(0, 3)) : cd1;
          b = rand_delays ? int'($urandom_range(3, 8)) : cd2;
          repeat (a) @(negedge clk);
          bus.container_done = 1'b0;
          repeat (b) @(negedge clk);
          bus.container_done = 1'b1;
          if (epoch == my_epoch) exp_runs++;
        end
      end
    end
  end

  task automatic put(input bit v, input int s, input int d, input logic [WW-1:0] w);
    @(posedge clk);
    #1;
    bus.wr_valid  = v;
    bus.wr_src    = PW'(s);
    bus.wr_dst    = PW'(d);
    bus.wr_weight = w;
  endtask

  task automatic wait_pulse(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (bus.container_reset) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_pulse actual=none required=pulse", name);
    end
  endtask

  task automatic wait_idle(input string name);
    int stable = 0;
    for (int i = 0; i < 4000 && stable < 4; i++) begin
      @(negedge clk);
      if (!busy && mq.size() == 0 && pending == 0) stable++;
      else stable = 0;
    end
    if (stable < 4) begin
      checks++;
      failures++;
      $display("FAIL %s_drain actual=busy required=idle", name);
    end
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int runs_before;
    bus.wr_valid  = 1'b0;
    bus.wr_src    = '0;
    bus.wr_dst    = '0;
    bus.wr_weight = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_pending",   64'(pending),   64'(0));
    chk("rst_busy",      64'(busy),      64'(0));
    chk("rst_run_count", 64'(run_count), 64'(0));
    chk("rst_error",     64'(error),     64'(0));
    chk("rst_u",         64'({bus.u_src, bus.u_dst, bus.u_e}), 64'(0));
    chk("rst_wr_ready",  64'(bus.wr_ready), 64'(1));

    // Single update through a full handshake
    put(1, 3, 5, 32'h10);
    put(0, 0, 0, 0);
    wait_pulse("single");
    chk("single_u", 64'({bus.u_src, bus.u_dst, bus.u_e}), 64'({6'd3, 6'd5, 32'h10}));
    wait_idle("single");
    chk("single_runs", 64'(run_count), 64'(1));

    // Coalescing while busy
    put(1, 4, 4, 32'h1);
    put(0, 0, 0, 0);
    wait_pulse("coal_first");
    put(1, 1, 2, 32'h7);
    put(1, 1, 2, 32'h9);
    put(0, 0, 0, 0);
    @(negedge clk);
    chk("coal_pending", 64'(pending), 64'(1));
    wait_pulse("coal_second");
    chk("coal_u", 64'({bus.u_src, bus.u_dst, bus.u_e}), 64'({6'd1, 6'd2, 32'h9}));
    wait_idle("coal");

    // Fill to DEPTH behind a long dispatch; ninth push refused
    cd2 = 30;
    put(1, 20, 21, 32'h5);
    put(0, 0, 0, 0);
    wait_pulse("fill_first");
    for (int i = 0; i <= DEPTH; i++) put(1, i, i + 1, 32'h100 + i);
    put(0, 0, 0, 0);
    @(negedge clk);
    chk("full_pending",  64'(pending),      64'(DEPTH));
    chk("full_wr_ready", 64'(bus.wr_ready), 64'(0));
    wait_idle("fill");
    cd2 = 10;

    // Randomised traffic over a small key space
    rand_delays = 1'b1;
    for (int i = 0; i < 300; i++) begin
      put($urandom_range(0, 2) == 0, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end
    put(0, 0, 0, 0);
    wait_idle("random");
    rand_delays = 1'b0;
    chk("random_error", 64'(error), 64'(0));

    // Container never completes: timeout, then the next entry still dispatches
    runs_before = exp_runs;
    hang_next = 1'b1;
    put(1, 7, 7, 32'h77);
    put(1, 8, 8, 32'h88);
    put(0, 0, 0, 0);
    wait_pulse("timeout");
    for (int i = 1; i <= TO + 1; i++) begin
      @(negedge clk);
      if (i == TO) begin
        chk("to_busy_before",  64'(busy),  64'(1));
        chk("to_error_before", 64'(error), 64'(0));
      end
    end
    chk("to_busy_after",  64'(busy),      64'(0));
    chk("to_error_after", 64'(error),     64'(1));
    chk("to_runs",        64'(run_count), 64'(runs_before));
    wait_idle("timeout_next");
    chk("to_next_runs",   64'(run_count), 64'(runs_before + 1));
    chk("to_error_stays", 64'(error),     64'(1));

    // Asynchronous reset in the middle of a dispatch with three queued
    cd1 = 0;
    cd2 = 8;
    put(1, 9, 1, 32'h21);
    put(0, 0, 0, 0);
    wait_pulse("reset_setup");
    put(1, 9, 2, 32'h22);
    put(1, 9, 3, 32'h23);
    put(1, 9, 4, 32'h24);
    put(0, 0, 0, 0);
    @(negedge clk);
    chk("pre_reset_pending", 64'(pending), 64'(3));
    chk("pre_reset_busy",    64'(busy),    64'(1));
    #2;
    reset_n  = 1'b0;
    epoch++;
    exp_runs = 0;
    #1;
    chk("arst_busy",      64'(busy),      64'(0));
    chk("arst_pending",   64'(pending),   64'(0));
    chk("arst_run_count", 64'(run_count), 64'(0));
    chk("arst_error",     64'(error),     64'(0));
    chk("arst_kick",      64'(bus.container_reset), 64'(0));
    chk("arst_u",         64'({bus.u_src, bus.u_dst, bus.u_e}), 64'(0));
    chk("arst_wr_ready",  64'(bus.wr_ready), 64'(1));
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_reset_busy",    64'(busy),      64'(0));
    chk("post_reset_pending", 64'(pending),   64'(0));
    chk("post_reset_runs",    64'(run_count), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
